// File: rtl/display_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : display_scan_scheduler_if
// Brief   : Read-port bundle between the display scan scheduler and the
//           shared register file (request / address / grant / data).
// Rev     : 1.0  initial release
// ============================================================================
interface display_scan_scheduler_if #(
  parameter int ADDR_W = 5
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [31:0]       rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_gnt,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_gnt,
    output rd_data
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : display_scan_scheduler
// Brief   : 8-digit hex display multiplexer; fetches one register per frame
//           and swaps it into the shown value only on frame boundaries.
// Rev     : 1.0  initial release
// ============================================================================
module display_scan_scheduler #(
  parameter int REFRESH_DIV = 100000,
  parameter int ADDR_W      = 5
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic [ADDR_W-1:0]      sel_addr,
  input  wire logic                   freeze,
  input  wire logic                   blank,
  display_scan_scheduler_if.master    rd,
  output logic [7:0]                  anodes,
  output logic [2:0]                  seg_sel,
  output logic [3:0]                  nibble,
  output logic                        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] c_TC = PW'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_presc;
  logic [2:0]        r_digit;
  logic [31:0]       r_shadow;
  logic [31:0]       r_pending;
  logic              r_pending_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_frame_done;

  logic w_tc;
  logic w_frame_end;

  assign w_tc        = (r_presc == c_TC);
  assign w_frame_end = w_tc && (r_digit == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_REQ;
      r_presc         <= '0;
      r_digit         <= 3'd0;
      r_shadow        <= 32'd0;
      r_pending       <= 32'd0;
      r_pending_valid <= 1'b0;
      r_rd_addr       <= '0;
      r_frame_done    <= 1'b0;
    end else begin
      r_presc      <= w_tc ? '0 : r_presc + PW'(1);
      r_frame_done <= w_frame_end;
      if (w_tc) begin
        r_digit <= r_digit + 3'd1;
      end

      // Swap only at frame end so a digit never shows a half-updated word.
      if (w_frame_end && r_pending_valid) begin
        r_shadow        <= r_pending;
        r_pending_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_frame_end && !freeze) begin
            r_state   <= ST_REQ;
            r_rd_addr <= sel_addr;
          end
        end
        ST_REQ: begin
          // A same-edge grant overrides the clear above: new data waits a frame.
          if (rd.rd_gnt) begin
            r_pending       <= rd.rd_data;
            r_pending_valid <= 1'b1;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd.rd_req  = (r_state == ST_REQ);
  assign rd.rd_addr = r_rd_addr;

  assign anodes     = blank ? 8'hFF : ~(8'd1 << r_digit);
  assign seg_sel    = r_digit;
  assign nibble     = r_shadow[{r_digit, 2'b00} +: 4];
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
